// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM states and
// the 3-sample majority vote.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO; the head entry is always visible on
// rd_data. Writes when full and reads when empty are ignored.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_wr   = wr_en && !full;
    do_rd   = rd_en && !empty;
    rd_data = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-vote sampling, error reporting and
// an output FIFO with valid/ready handshake toward the instruction loader.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY      = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun,
  input  logic                 i_clr_err,
  output logic [7:0]           o_byte_count,
  output logic                 o_busy
);

  localparam int unsigned     CW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0]   C_S0  = CW'(CLK_PER_BIT/2 - 1);
  localparam logic [CW-1:0]   C_S1  = CW'(CLK_PER_BIT/2);
  localparam logic [CW-1:0]   C_DEC = CW'(CLK_PER_BIT/2 + 1);
  localparam logic [CW-1:0]   C_END = CW'(CLK_PER_BIT - 1);

  rx_state_t            state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp0, samp1;
  logic                 par_err, stop_err;

  logic bit_v, at_dec, at_end, exp_par, last_stop, frame_bad, good;
  logic fifo_wr, fifo_full, fifo_empty, ovr_set;

  always_comb begin
    bit_v     = maj3(samp0, samp1, rx_sync);
    at_dec    = (cnt == C_DEC);
    at_end    = (cnt == C_END);
    exp_par   = (PARITY == PAR_ODD) ? ~^shreg : ^shreg;
    last_stop = (state == ST_STOP) && at_dec && (stop_idx == 1'(STOP_BITS - 1));
    frame_bad = stop_err | ~bit_v;
    good      = last_stop && !frame_bad && !par_err;
    fifo_wr   = good && !fifo_full;
    ovr_set   = good && fifo_full;
    o_valid   = !fifo_empty;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      rx_prev      <= 1'b1;
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shreg        <= '0;
      samp0        <= 1'b1;
      samp1        <= 1'b1;
      par_err      <= 1'b0;
      stop_err     <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overrun    <= 1'b0;
      o_byte_count <= '0;
      o_busy       <= 1'b0;
    end else begin
      rx_meta      <= i_rx;
      rx_sync      <= rx_meta;
      rx_prev      <= rx_sync;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;

      if (ovr_set)        o_overrun <= 1'b1;
      else if (i_clr_err) o_overrun <= 1'b0;
      if (fifo_wr) o_byte_count <= o_byte_count + 8'd1;

      if (state == ST_IDLE) begin
        if (rx_prev && !rx_sync) begin
          state  <= ST_START;
          cnt    <= '0;
          o_busy <= 1'b1;
        end
      end else begin
        if (cnt == C_S0) samp0 <= rx_sync;
        if (cnt == C_S1) samp1 <= rx_sync;
        cnt <= at_end ? '0 : cnt + 1'b1;

        case (state)
          ST_START: begin
            if (at_dec && bit_v) begin
              state  <= ST_IDLE;
              o_busy <= 1'b0;
            end else if (at_end) begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              par_err  <= 1'b0;
              stop_err <= 1'b0;
            end
          end
          ST_DATA: begin
            if (at_dec) shreg <= {bit_v, shreg[DATA_BITS-1:1]};
            if (at_end) begin
              if (bit_idx == 4'(DATA_BITS - 1))
                state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              else
                bit_idx <= bit_idx + 4'd1;
            end
          end
          ST_PARITY: begin
            if (at_dec) par_err <= bit_v ^ exp_par;
            if (at_end) state <= ST_STOP;
          end
          ST_STOP: begin
            // The last stop bit commits at its mid-bit decision so the next
            // start edge can be caught without a dead half-bit.
            if (at_dec) begin
              stop_err <= frame_bad;
              if (last_stop) begin
                o_frame_err  <= frame_bad;
                o_parity_err <= par_err;
                state        <= ST_IDLE;
                o_busy       <= 1'b0;
              end
            end else if (at_end) begin
              stop_idx <= 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .wr_en  (fifo_wr),
    .wr_data(shreg),
    .rd_en  (i_ready),
    .rd_data(o_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule
